// File: rtl/aes_seq_pkg.sv
// Shared types for the AES round sequencer: FSM states, key-length codes and round-count lookup.
// The KEXP state only exists when AES_SEQ_DECRYPT_EN is defined.
package aes_seq_pkg;

    localparam logic [1:0] KL_128  = 2'd0;
    localparam logic [1:0] KL_192  = 2'd1;
    localparam logic [1:0] KL_256  = 2'd2;
    localparam logic [1:0] KL_RSVD = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
`ifdef AES_SEQ_DECRYPT_EN
        KEXP  = 3'd2,
`endif
        ROUND = 3'd3,
        OUT   = 3'd4
    } seq_state_e;

    function automatic logic [3:0] nr_of(input logic [1:0] keylen);
        logic [3:0] nr;
        case (keylen)
            KL_128:  nr = 4'd10;
            KL_192:  nr = 4'd12;
            KL_256:  nr = 4'd14;
            default: nr = 4'd0;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_timer.sv
// Per-round watchdog: counts stalled ROUND cycles and flags the cycle in which the
// TIMEOUT-th consecutive stall occurs, so the sequencer can leave ROUND on that edge.
module aes_round_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic refclk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_r;

    // Saturating stall counter, restarted by clear
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (clear) begin
            cnt_r <= 8'd0;
        end else if (count_en && (cnt_r != 8'hFF)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = count_en && (cnt_r >= LIMIT);

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES round sequencer: load, optional decrypt key pre-pass, Nr handshaked rounds, status.
// Decrypt support (KEXP, ks_fwd, dp_dec) is compiled in only with AES_SEQ_DECRYPT_EN.
module aes_round_seq
    import aes_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_keylen,
    input  logic       cmd_dec,
    output logic       dp_load,
    output logic [1:0] dp_keylen,
    output logic       dp_dec,
    output logic       ks_fwd,
    output logic       dp_round_valid,
    output logic [3:0] dp_round_idx,
    output logic       dp_round_last,
    input  logic       dp_done,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_err,
    output logic       busy
);

    seq_state_e state_r;
    logic       cmd_ready_r, dp_load_r, dp_round_valid_r, dp_round_last_r;
    logic       res_valid_r, res_err_r, busy_r;
    logic [1:0] dp_keylen_r;
    logic [3:0] rnd_r;
    logic [3:0] nr_s;
    logic       transfer_s, reject_s, wd_clear_s, wd_count_s, wd_expired_s;
`ifdef AES_SEQ_DECRYPT_EN
    logic       ks_fwd_r, dp_dec_r;
`endif

    assign nr_s       = nr_of(dp_keylen_r);
    assign transfer_s = dp_round_valid_r & dp_done;
    assign wd_count_s = (state_r == ROUND) & ~dp_done;
    assign wd_clear_s = (state_r != ROUND) | transfer_s;
`ifdef AES_SEQ_DECRYPT_EN
    assign reject_s   = (cmd_keylen == KL_RSVD);
`else
    assign reject_s   = (cmd_keylen == KL_RSVD) | cmd_dec;
`endif

    aes_round_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .clear    (wd_clear_s),
        .count_en (wd_count_s),
        .expired  (wd_expired_s)
    );

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            cmd_ready_r      <= 1'b0;
            dp_load_r        <= 1'b0;
            dp_round_valid_r <= 1'b0;
            dp_round_last_r  <= 1'b0;
            res_valid_r      <= 1'b0;
            res_err_r        <= 1'b0;
            busy_r           <= 1'b0;
            dp_keylen_r      <= 2'd0;
            rnd_r            <= 4'd0;
`ifdef AES_SEQ_DECRYPT_EN
            ks_fwd_r         <= 1'b0;
            dp_dec_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    // cmd_ready is low for the first cycle after reset release
                    if (cmd_ready_r && cmd_valid) begin
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        dp_keylen_r <= cmd_keylen;
`ifdef AES_SEQ_DECRYPT_EN
                        dp_dec_r    <= cmd_dec;
`endif
                        if (reject_s) begin
                            state_r     <= OUT;
                            res_valid_r <= 1'b1;
                            res_err_r   <= 1'b1;
                        end else begin
                            state_r   <= LOAD;
                            dp_load_r <= 1'b1;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                LOAD: begin
                    dp_load_r <= 1'b0;
                    rnd_r     <= 4'd1;
`ifdef AES_SEQ_DECRYPT_EN
                    if (dp_dec_r) begin
                        state_r  <= KEXP;
                        ks_fwd_r <= 1'b1;
                    end else begin
                        state_r          <= ROUND;
                        dp_round_valid_r <= 1'b1;
                        dp_round_last_r  <= 1'b0;
                    end
`else
                    state_r          <= ROUND;
                    dp_round_valid_r <= 1'b1;
                    dp_round_last_r  <= 1'b0;
`endif
                end
`ifdef AES_SEQ_DECRYPT_EN
                KEXP: begin
                    if (rnd_r == nr_s) begin
                        ks_fwd_r         <= 1'b0;
                        state_r          <= ROUND;
                        rnd_r            <= 4'd1;
                        dp_round_valid_r <= 1'b1;
                        dp_round_last_r  <= 1'b0;
                    end else begin
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
`endif
                ROUND: begin
                    if (transfer_s) begin
                        if (rnd_r == nr_s) begin
                            state_r          <= OUT;
                            dp_round_valid_r <= 1'b0;
                            dp_round_last_r  <= 1'b0;
                            res_valid_r      <= 1'b1;
                            res_err_r        <= 1'b0;
                        end else begin
                            rnd_r           <= rnd_r + 4'd1;
                            dp_round_last_r <= ((rnd_r + 4'd1) == nr_s);
                        end
                    end else if (wd_expired_s) begin
                        state_r          <= OUT;
                        dp_round_valid_r <= 1'b0;
                        dp_round_last_r  <= 1'b0;
                        res_valid_r      <= 1'b1;
                        res_err_r        <= 1'b1;
                    end else begin
                        state_r <= ROUND;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state_r     <= IDLE;
                        res_valid_r <= 1'b0;
                        res_err_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    cmd_ready_r      <= 1'b0;
                    dp_load_r        <= 1'b0;
                    dp_round_valid_r <= 1'b0;
                    dp_round_last_r  <= 1'b0;
                    res_valid_r      <= 1'b0;
                    res_err_r        <= 1'b0;
                    busy_r           <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign dp_load        = dp_load_r;
    assign dp_keylen      = dp_keylen_r;
    assign dp_round_valid = dp_round_valid_r;
    assign dp_round_idx   = rnd_r;
    assign dp_round_last  = dp_round_last_r;
    assign res_valid      = res_valid_r;
    assign res_err        = res_err_r;
    assign busy           = busy_r;
`ifdef AES_SEQ_DECRYPT_EN
    assign ks_fwd         = ks_fwd_r;
    assign dp_dec         = dp_dec_r;
`else
    assign ks_fwd         = 1'b0;
    assign dp_dec         = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
// Scoreboard bench for aes_round_seq: a latency/status model predicts each command's result,
// a stalling datapath responder drives dp_done, and a monitor checks outputs at negedges.
module tb_aes_round_seq;

    localparam int TMO = 8;
`ifdef AES_SEQ_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct {
        logic err;
        int   lat;
        int   nr;
        int   loads;
        int   ks;
    } exp_t;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_keylen = 2'd0;
    logic       cmd_dec = 1'b0;
    logic       dp_done = 1'b1;
    logic       res_ready = 1'b0;
    logic       cmd_ready, dp_load, dp_dec, ks_fwd, dp_round_valid, dp_round_last;
    logic       res_valid, res_err, busy;
    logic [1:0] dp_keylen;
    logic [3:0] dp_round_idx;

    aes_round_seq #(.TIMEOUT(TMO)) dut (
        .refclk         (refclk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_keylen     (cmd_keylen),
        .cmd_dec        (cmd_dec),
        .dp_load        (dp_load),
        .dp_keylen      (dp_keylen),
        .dp_dec         (dp_dec),
        .ks_fwd         (ks_fwd),
        .dp_round_valid (dp_round_valid),
        .dp_round_idx   (dp_round_idx),
        .dp_round_last  (dp_round_last),
        .dp_done        (dp_done),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_err        (res_err),
        .busy           (busy)
    );

    always #5 refclk = ~refclk;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   stall_round = 0;
    int   stall_left = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    function automatic logic [14:0] outs_now();
        return {cmd_ready, dp_load, dp_keylen, dp_dec, ks_fwd, dp_round_valid,
                dp_round_idx, dp_round_last, res_valid, res_err, busy};
    endfunction

    // Reference: latency in cycles from acceptance to res_valid, plus status and pulse counts
    function automatic exp_t model(input int kl, input bit dec, input int sr, input int sl);
        exp_t e;
        int   nr, base;
        nr   = (kl == 0) ? 10 : (kl == 1) ? 12 : 14;
        e.nr = nr;
        if (kl == 3 || (dec && !DEC_EN)) begin
            e.err = 1'b1; e.lat = 1; e.loads = 0; e.ks = 0;
            return e;
        end
        base    = dec ? 2 + nr : 2;
        e.loads = 1;
        e.ks    = dec ? nr : 0;
        if (sl >= TMO) begin
            e.err = 1'b1;
            e.lat = base + (sr - 1) + TMO;
        end else begin
            e.err = 1'b0;
            e.lat = base + nr + sl;
        end
        return e;
    endfunction

    // Datapath responder: withholds dp_done for stall_left cycles on round stall_round
    initial begin
        forever begin
            tick();
            if (dp_round_valid && dp_round_idx == stall_round[3:0] && stall_left > 0) begin
                dp_done = 1'b0;
                stall_left--;
            end else begin
                dp_done = 1'b1;
            end
        end
    end

    // Monitor: per-cycle protocol checks and scoreboard pop on each new result
    initial begin : monitor
        int   t_acc, exp_idx, n_load, n_ks, cur_nr;
        bit   res_seen;
        exp_t cur;
        t_acc = 0; exp_idx = 0; n_load = 0; n_ks = 0; cur_nr = 0; res_seen = 1'b0;
        cur = '{err: 1'b0, lat: 0, nr: 0, loads: 0, ks: 0};
        forever begin
            @(negedge refclk);
            if (!rst_n) begin
                res_seen = 1'b0;
                exp_idx  = 0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    t_acc = cyc; exp_idx = 1; n_load = 0; n_ks = 0;
                    cur_nr = (sb_q.size() > 0) ? sb_q[0].nr : 0;
                end
                if (dp_load) begin
                    n_load++;
                    chk("load_time", cyc - t_acc, 1);
                end
                if (ks_fwd) n_ks++;
                if (dp_round_valid) begin
                    chk("round_idx", dp_round_idx, exp_idx);
                    chk("round_last", dp_round_last, exp_idx == cur_nr);
                    if (dp_done) exp_idx++;
                end
                if (res_valid && !res_seen) begin
                    res_seen = 1'b1;
                    if (sb_q.size() == 0) begin
                        chk("res_unexpected", 1, 0);
                    end else begin
                        cur = sb_q.pop_front();
                        chk("res_latency", cyc - t_acc, cur.lat);
                        chk("res_err", res_err, cur.err);
                        chk("load_count", n_load, cur.loads);
                        chk("ks_count", n_ks, cur.ks);
                    end
                end
                if (res_valid) begin
                    chk("res_err_stable", res_err, cur.err);
                    chk("ready_in_out", cmd_ready, 0);
                    chk("valid_in_out", dp_round_valid, 0);
                    chk("busy_in_out", busy, 1);
                    if (res_ready) res_seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int kl, input bit dec);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_keylen = 2'(kl);
        cmd_dec    = dec;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic run_cmd(input int kl, input bit dec, input int sr, input int sl, input int hold);
        int n;
        sb_q.push_back(model(kl, dec, sr, sl));
        stall_round = sr;
        stall_left  = sl;
        issue(kl, dec);
        n = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
        chk("res_valid_wait", res_valid, 1);
        repeat (hold) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outputs", outs_now(), 0);
        #2 rst_n = 1'b1;
        #1;
        chk("ready_before_edge", cmd_ready, 0);
        tick();
        chk("ready_after_release", cmd_ready, 1);

        run_cmd(0, 1'b0, 1, 0, 0);
        run_cmd(2, 1'b1, 5, 2, 1);
        run_cmd(3, 1'b0, 1, 0, 5);
        run_cmd(0, 1'b0, 3, TMO, 0);
        run_cmd(1, 1'b0, 7, TMO - 1, 2);
        run_cmd(0, 1'b1, 2, 0, 0);

        // Abandon an AES-192 command mid-round, then confirm normal operation afterwards
        sb_q.push_back(model(1, 1'b0, 1, 0));
        stall_round = 1;
        stall_left  = 0;
        issue(1, 1'b0);
        repeat (5) tick();
        chk("mid_round_valid", dp_round_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs_now(), 0);
        sb_q.delete();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        run_cmd(0, 1'b0, 1, 0, 0);

        for (int i = 0; i < 24; i++) begin
            int kl, sr, sl, hold;
            bit dec;
            kl   = int'($urandom_range(0, 3));
            dec  = 1'($urandom_range(0, 1));
            sr   = int'($urandom_range(1, (kl == 0) ? 10 : (kl == 1) ? 12 : 14));
            sl   = ($urandom_range(0, 5) == 0) ? TMO + 3 : int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 3));
            run_cmd(kl, dec, sr, sl, hold);
        end

        chk("queue_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
